// File: rtl/wb_axis_bridge.sv
// Wishbone-slave to AXI-Stream bridge: TX FIFO (WB writes -> stream master), RX FIFO (stream slave -> WB reads).
// Optional feature macro WB_AXIS_TLAST_EN carries tlast through both FIFOs and enables the TXLAST register.
module wb_axis_bridge #(
    parameter int          DATA_W    = 32,
    parameter int          TX_DEPTH  = 8,
    parameter int          RX_DEPTH  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0080
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              sm_tvalid,
    input  logic              sm_tready,
    output logic [DATA_W-1:0] sm_tdata,
    output logic              sm_tlast,
    input  logic              ss_tvalid,
    output logic              ss_tready,
    input  logic [DATA_W-1:0] ss_tdata,
    input  logic              ss_tlast
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int TX_CW = TX_AW + 1;
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int RX_CW = RX_AW + 1;

    // state  | meaning
    // S_IDLE | waiting for a decode hit whose resource is available
    // S_ACK  | acknowledge driven for exactly one cycle
    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              w_hit;
    logic [1:0]        w_off;
    logic              w_is_tx_wr;
    logic              w_is_rx_rd;
    logic              w_accept;
    logic [31:0]       w_rd_data;
    logic [31:0]       w_status;
    logic [31:0]       r_dat_o;
    logic              r_rdy;
    logic              w_unused;

    logic [TX_AW-1:0]  r_tx_wr_ptr;
    logic [TX_AW-1:0]  r_tx_rd_ptr;
    logic [TX_CW-1:0]  r_tx_cnt;
    logic [DATA_W-1:0] r_tx_mem [TX_DEPTH];
    logic              w_tx_full;
    logic              w_tx_empty;
    logic              w_tx_push;
    logic              w_tx_pop;
    logic              w_tx_head_last;

    logic [RX_AW-1:0]  r_rx_wr_ptr;
    logic [RX_AW-1:0]  r_rx_rd_ptr;
    logic [RX_CW-1:0]  r_rx_cnt;
    logic [DATA_W-1:0] r_rx_mem [RX_DEPTH];
    logic              w_rx_full;
    logic              w_rx_empty;
    logic              w_rx_push;
    logic              w_rx_pop;
    logic              w_rx_head_last;

    assign w_hit      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign w_off      = wbs_adr_i[3:2];
    assign w_is_tx_wr = wbs_we_i & ((w_off == 2'd0) | (w_off == 2'd3));
    assign w_is_rx_rd = ~wbs_we_i & (w_off == 2'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hit && !(w_is_tx_wr && w_tx_full) && !(w_is_rx_rd && w_rx_empty)) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign wbs_ack_o = (r_state == S_ACK);
    assign wbs_dat_o = r_dat_o;

    assign w_status = {8'h00, 8'(r_rx_cnt), 8'(r_tx_cnt), 3'b000,
                       w_rx_head_last, w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};

    always_comb begin
        w_rd_data = '0;
        if (!wbs_we_i) begin
            case (w_off)
                2'd1:    w_rd_data = 32'(r_rx_mem[r_rx_rd_ptr]);
                2'd2:    w_rd_data = w_status;
                default: w_rd_data = '0;
            endcase
        end
    end

    // Write acks also load zero so stale read data never outlives the next ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dat_o <= '0;
        end else if (w_accept) begin
            r_dat_o <= w_rd_data;
        end
    end

    // TX FIFO
    assign w_tx_full  = (r_tx_cnt == TX_CW'(TX_DEPTH));
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_push  = w_accept & w_is_tx_wr;
    assign w_tx_pop   = sm_tvalid & sm_tready;

    assign sm_tvalid = ~w_tx_empty;
    assign sm_tdata  = w_tx_empty ? '0 : r_tx_mem[r_tx_rd_ptr];
    assign sm_tlast  = ~w_tx_empty & w_tx_head_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
            r_tx_cnt    <= '0;
        end else begin
            if (w_tx_push) begin
                r_tx_wr_ptr <= r_tx_wr_ptr + TX_AW'(1);
            end
            if (w_tx_pop) begin
                r_tx_rd_ptr <= r_tx_rd_ptr + TX_AW'(1);
            end
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + TX_CW'(1);
                2'b01:   r_tx_cnt <= r_tx_cnt - TX_CW'(1);
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr_ptr] <= wbs_dat_i[DATA_W-1:0];
        end
    end

    // RX FIFO; r_rdy keeps ss_tready low until the first edge after reset release.
    assign w_rx_full  = (r_rx_cnt == RX_CW'(RX_DEPTH));
    assign w_rx_empty = (r_rx_cnt == '0);
    assign ss_tready  = r_rdy & ~w_rx_full;
    assign w_rx_push  = ss_tvalid & ss_tready;
    assign w_rx_pop   = w_accept & w_is_rx_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy <= 1'b0;
        end else begin
            r_rdy <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
            r_rx_cnt    <= '0;
        end else begin
            if (w_rx_push) begin
                r_rx_wr_ptr <= r_rx_wr_ptr + RX_AW'(1);
            end
            if (w_rx_pop) begin
                r_rx_rd_ptr <= r_rx_rd_ptr + RX_AW'(1);
            end
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + RX_CW'(1);
                2'b01:   r_rx_cnt <= r_rx_cnt - RX_CW'(1);
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wr_ptr] <= ss_tdata;
        end
    end

`ifdef WB_AXIS_TLAST_EN
    logic r_tx_last_mem [TX_DEPTH];
    logic r_rx_last_mem [RX_DEPTH];

    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_last_mem[r_tx_wr_ptr] <= (w_off == 2'd3);
        end
        if (w_rx_push) begin
            r_rx_last_mem[r_rx_wr_ptr] <= ss_tlast;
        end
    end

    assign w_tx_head_last = r_tx_last_mem[r_tx_rd_ptr];
    assign w_rx_head_last = ~w_rx_empty & r_rx_last_mem[r_rx_rd_ptr];
    assign w_unused       = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i};
`else
    assign w_tx_head_last = 1'b0;
    assign w_rx_head_last = 1'b0;
    assign w_unused       = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i, ss_tlast};
`endif

endmodule

// File: tb/tb_wb_axis_bridge.sv
// Self-checking bench for wb_axis_bridge: register vector table, TX/RX scoreboards and
// hand-written sequences for stalls, latency, tlast handling and mid-transfer reset.
module tb_wb_axis_bridge;

    localparam int          DW   = 32;
    localparam logic [31:0] BASE = 32'h3000_0080;
`ifdef WB_AXIS_TLAST_EN
    localparam bit TL = 1'b1;
`else
    localparam bit TL = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]    wbs_sel_i;
    logic [31:0]   wbs_adr_i, wbs_dat_i;
    logic          wbs_ack_o;
    logic [31:0]   wbs_dat_o;
    logic          sm_tvalid, sm_tready, sm_tlast;
    logic [DW-1:0] sm_tdata;
    logic          ss_tvalid, ss_tready, ss_tlast;
    logic [DW-1:0] ss_tdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] tx_q[$];
    logic [31:0] rx_q[$];

    typedef struct {
        logic        we;
        logic [3:0]  off;
        logic [31:0] wdata;
        logic        rd_chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    wb_axis_bridge #(
        .DATA_W   (DW),
        .TX_DEPTH (8),
        .RX_DEPTH (8),
        .BASE_ADDR(BASE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wbs_cyc_i(wbs_cyc_i),
        .wbs_stb_i(wbs_stb_i),
        .wbs_we_i (wbs_we_i),
        .wbs_sel_i(wbs_sel_i),
        .wbs_adr_i(wbs_adr_i),
        .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o),
        .wbs_dat_o(wbs_dat_o),
        .sm_tvalid(sm_tvalid),
        .sm_tready(sm_tready),
        .sm_tdata (sm_tdata),
        .sm_tlast (sm_tlast),
        .ss_tvalid(ss_tvalid),
        .ss_tready(ss_tready),
        .ss_tdata (ss_tdata),
        .ss_tlast (ss_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Stream-master monitor: pops the TX scoreboard on each accepted beat and checks tvalid hold.
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic [32:0] pd = '0;
    always @(negedge clk) begin
        if (rst_n && pv && !pr)
            chk("tvalid_hold", {31'd0, sm_tvalid, sm_tlast, sm_tdata}, {31'd0, 1'b1, pd});
        if (rst_n && sm_tvalid && sm_tready) begin
            if (tx_q.size() == 0)
                chk("tx_unexpected_beat", {31'd0, sm_tlast, sm_tdata}, 64'hDEAD);
            else
                chk("tx_beat", {31'd0, sm_tlast, sm_tdata}, {31'd0, tx_q.pop_front()});
        end
        pv = rst_n & sm_tvalid;
        pr = sm_tready;
        pd = {sm_tlast, sm_tdata};
    end

    task automatic wb_xfer(input logic we, input logic [3:0] off, input logic [31:0] wd,
                           output logic [31:0] rd);
        int n;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = BASE + {28'd0, off};
        wbs_dat_i = wd;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!wbs_ack_o && n < 50);
        rd = wbs_dat_o;
        if (!wbs_ack_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL wb_ack_timeout: got no ack expected ack for offset 0x%0h", off);
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    task automatic wb_write(input logic [3:0] off, input logic [31:0] d);
        logic [31:0] rd;
        if (off == 4'h0 || off == 4'hC)
            tx_q.push_back({(off == 4'hC) & TL, d});
        wb_xfer(1'b1, off, d, rd);
    endtask

    task automatic wb_read(input logic [3:0] off, output logic [31:0] rd);
        wb_xfer(1'b0, off, 32'd0, rd);
    endtask

    task automatic ss_send(input logic [31:0] d, input logic l);
        int n;
        ss_tvalid = 1'b1;
        ss_tdata  = d[DW-1:0];
        ss_tlast  = l;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ss_tready && n < 50);
        if (!ss_tready) begin
            n_checks++;
            n_fail++;
            $display("FAIL ss_ready_timeout: got ss_tready=0 expected 1");
        end else begin
            rx_q.push_back(d);
        end
        @(posedge clk);
        #1;
        ss_tvalid = 1'b0;
        ss_tlast  = 1'b0;
    endtask

    task automatic tx_drain();
        int n;
        sm_tready = 1'b1;
        n = 0;
        while ((tx_q.size() != 0 || sm_tvalid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("tx_drain_left", tx_q.size(), 0);
        sm_tready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        acked;
        int          n;

        vecs[0]  = '{1'b0, 4'h8, 32'h0,         1'b1, 32'h0000_000A};
        vecs[1]  = '{1'b1, 4'h0, 32'h11,        1'b0, 32'h0};
        vecs[2]  = '{1'b0, 4'h8, 32'h0,         1'b1, 32'h0000_0108};
        vecs[3]  = '{1'b0, 4'h0, 32'h0,         1'b1, 32'h0};
        vecs[4]  = '{1'b1, 4'h8, 32'hFFFF_FFFF, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 4'h8, 32'h0,         1'b1, 32'h0000_0108};
        vecs[6]  = '{1'b1, 4'hC, 32'h22,        1'b0, 32'h0};
        vecs[7]  = '{1'b0, 4'h8, 32'h0,         1'b1, 32'h0000_0208};
        vecs[8]  = '{1'b0, 4'hC, 32'h0,         1'b1, 32'h0};
        vecs[9]  = '{1'b1, 4'h4, 32'h1234,      1'b0, 32'h0};
        vecs[10] = '{1'b0, 4'h8, 32'h0,         1'b1, 32'h0000_0208};

        rst_n     = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'hF;
        wbs_adr_i = '0;
        wbs_dat_i = '0;
        sm_tready = 1'b0;
        ss_tvalid = 1'b0;
        ss_tdata  = '0;
        ss_tlast  = 1'b0;

        // Reset state and ss_tready release timing.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {wbs_ack_o, sm_tvalid, sm_tlast, ss_tready}, 4'b0000);
        chk("rst_dat_o", wbs_dat_o, 32'h0);
        chk("rst_tdata", sm_tdata, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("ss_tready_before_edge", ss_tready, 1'b0);
        @(posedge clk);
        #1;
        chk("ss_tready_after_edge", ss_tready, 1'b1);

        // Register map vectors.
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].we && (vecs[i].off == 4'h0 || vecs[i].off == 4'hC))
                tx_q.push_back({(vecs[i].off == 4'hC) & TL, vecs[i].wdata});
            wb_xfer(vecs[i].we, vecs[i].off, vecs[i].wdata, rd);
            if (vecs[i].rd_chk)
                chk($sformatf("vec%0d", i), rd, vecs[i].exp);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("dat_o_hold", wbs_dat_o, 32'h0000_0208);

        // Address miss: no ack.
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_adr_i = BASE + 32'h10;
        acked = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (wbs_ack_o) acked = 1'b1;
        end
        chk("miss_no_ack", acked, 1'b0);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;

        tx_drain();

        // Fill TX, stall the ninth write, release it by draining.
        for (int i = 1; i <= 8; i++)
            wb_write(4'h0, 32'(i));
        wb_read(4'h8, rd);
        chk("status_tx_full", rd, 32'h0000_0809);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b1;
        wbs_adr_i = BASE;
        wbs_dat_i = 32'd9;
        tx_q.push_back({1'b0, 32'd9});
        acked = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (wbs_ack_o) acked = 1'b1;
        end
        chk("tx_full_stall", acked, 1'b0);
        sm_tready = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!wbs_ack_o && n < 20);
        chk("tx_ninth_ack", wbs_ack_o, 1'b1);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        tx_drain();

        // Fill RX, then read it back in order.
        for (int i = 0; i < 8; i++)
            ss_send(32'hA0 + 32'(i), 1'b0);
        chk("ss_tready_full", ss_tready, 1'b0);
        wb_read(4'h8, rd);
        chk("status_rx_full", rd, 32'h0008_0006);
        for (int i = 0; i < 8; i++) begin
            wb_read(4'h4, rd);
            chk($sformatf("rx_read%0d", i), rd, rx_q.pop_front());
        end
        wb_read(4'h8, rd);
        chk("status_after_rx", rd, 32'h0000_000A);

        // Stalled RXDATA read released by a stream beat; ack two edges after injection.
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_adr_i = BASE + 32'h4;
        acked = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (wbs_ack_o) acked = 1'b1;
        end
        chk("rx_empty_stall", acked, 1'b0);
        ss_tvalid = 1'b1;
        ss_tdata  = 32'h55;
        ss_tlast  = 1'b0;
        rx_q.push_back(32'h55);
        @(posedge clk);
        #1;
        ss_tvalid = 1'b0;
        chk("rx_ack_not_early", wbs_ack_o, 1'b0);
        @(posedge clk);
        #1;
        chk("rx_ack_latency", wbs_ack_o, 1'b1);
        chk("rx_stalled_data", wbs_dat_o, rx_q.pop_front());
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;

        // tlast handling (or its absence).
        wb_write(4'hC, 32'h7);
        chk("txlast_beat", {sm_tvalid, sm_tlast, sm_tdata}, {1'b1, TL, 32'h7});
        tx_drain();
        ss_send(32'h3C, 1'b1);
        wb_read(4'h8, rd);
        chk("status_rx_last", rd, 32'h0001_0002 | (TL ? 32'h10 : 32'h0));
        wb_read(4'h4, rd);
        chk("rx_last_data", rd, rx_q.pop_front());

        // Reset while TX holds 3 words and an RX read is stalled.
        for (int i = 0; i < 3; i++)
            wb_write(4'h0, 32'hC0 + 32'(i));
        wb_read(4'h8, rd);
        chk("status_tx3", rd, 32'h0000_0308);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_adr_i = BASE + 32'h4;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", {wbs_ack_o, sm_tvalid, sm_tlast, ss_tready}, 4'b0000);
        chk("midrst_dat_o", wbs_dat_o, 32'h0);
        chk("midrst_tdata", sm_tdata, 32'h0);
        tx_q.delete();
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", {ss_tready, sm_tvalid}, 2'b10);
        wb_read(4'h8, rd);
        chk("post_rst_status", rd, 32'h0000_000A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_axis_bridge.md
# wb_axis_bridge

Buffered, parametrised Wishbone-slave to AXI-Stream bridge for the user project area, replacing the combinational pass-through bridge between the Caravel Wishbone bus and the FIR stream ports. It has a TX FIFO that turns Wishbone writes into an AXI-Stream master, and an RX FIFO that turns an AXI-Stream slave into Wishbone reads. A status register lets firmware poll FIFO levels instead of stalling the bus.

## Interface
- DATA_W, 32: stream data width, 1..32. Wishbone writes use wbs_dat_i[DATA_W-1:0]; reads are zero-extended to 32 bits.
- TX_DEPTH, 8: TX FIFO depth. Power of two, 2..128.
- RX_DEPTH, 8: RX FIFO depth. Power of two, 2..128.
- BASE_ADDR, 32'h3000_0080: base address of the 16-byte register window.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous and active-low.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1  Wishbone cycle, strobe and write-enable.
- wbs_sel_i  in  4  byte selects. Ignored: all accesses are full-word.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  single-cycle acknowledge.
- wbs_dat_o  out  32  read data.
- sm_tvalid  out  1,  sm_tready  in  1,  sm_tdata  out  DATA_W,  sm_tlast  out  1: stream master (to FIR).
- ss_tvalid  in  1,  ss_tready  out  1,  ss_tdata  in  DATA_W,  ss_tlast  in  1: stream slave (from FIR).

## Operation
- Decode hit: cyc & stb & (wbs_adr_i[31:4] == BASE_ADDR[31:4]). Misses are ignored with no ack, because other slaves own them.
- Register map (offset from BASE_ADDR):
  - 0x0 TXDATA (W): push with last=0.
  - 0x4 RXDATA (R): pop.
  - 0x8 STATUS (R).
  - 0xC TXLAST (W): push with last=1.
- STATUS bits: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] last flag of the RX head word (0 if empty), [15:8] tx_count, [23:16] rx_count, others 0.
- Accesses that do nothing ack normally: reads of write-only offsets return 0; writes to read-only offsets are dropped.
- Bus FSM has two states: IDLE and ACK.
  - IDLE → ACK on a decode hit whose resource is available. The action is performed on that edge.
  - TXDATA/TXLAST write with tx_full: stay in IDLE (bus stalls) until space frees.
  - RXDATA read with rx_empty: stay in IDLE (bus stalls) until a word arrives.
  - ACK → IDLE unconditionally. wbs_ack_o = 1 only in ACK, so the same strobe is never acked twice.
- TX FIFO:
  - sm_tvalid = !tx_empty; sm_tdata and sm_tlast come from the head entry.
  - Pop on sm_tvalid & sm_tready.
  - Push and pop in the same cycle are allowed (count unchanged). A push is still refused when the registered count is full, even if a pop occurs that cycle.
- RX FIFO:
  - ss_tready = rdy_q & !rx_full. rdy_q is a flop, cleared by reset and set on the first clk edge after rst_n rises.
  - Push on ss_tvalid & ss_tready, storing {ss_tlast, ss_tdata}.
  - Simultaneous push and Wishbone pop are legal.
- Pointers wrap modulo depth. Counts are $clog2(DEPTH)+1 bits, so a full FIFO reads DEPTH, not 0.

## Timing
- Reset (asynchronous, immediate): FSM IDLE, FIFOs empty, pointers 0.
  - wbs_ack_o=0, wbs_dat_o=0, sm_tvalid=0, sm_tdata=0, sm_tlast=0, ss_tready=0.
- Wishbone latency: request sampled at edge N, ack high N+1 to N+2. wbs_dat_o is registered at edge N and held until the next ack.
- Write to stream: push at edge N; sm_tvalid high from N, so a word can leave at edge N+1 at the earliest.
- Stream to read: word accepted at edge N is visible in STATUS and poppable by a request sampled at N+1.
- Reset asserted mid-transfer: an in-flight ack is dropped and FIFO contents are lost. No stream handshake may complete while rst_n is low.
- sm_tvalid, once high, stays high until its beat is accepted, per AXI-Stream rules.

## Configuration
- WB_AXIS_TLAST_EN:
  - Defined: TXLAST pushes last=1; ss_tlast is stored; STATUS[4] reports the RX head's last flag; sm_tlast is driven from the FIFO.
  - Undefined: the FIFO stores no last bit. TXLAST behaves exactly like TXDATA. sm_tlast is tied to 0, ss_tlast is ignored, and STATUS[4] reads 0.

## Test plan
- Reset, then read STATUS → 0x0000_000A (tx_empty, rx_empty); ss_tready=1 one edge after rst_n rises; sm_tvalid=0.
- Write 1..8 to TXDATA with sm_tready=0 → 8 acks, STATUS tx_count=8 and tx_full=1. Ninth write stalls with no ack. Raise sm_tready → beats 1..8 emerge in order, and the ninth write acks once space frees.
- Drive 8 beats 0xA0..0xA7 on ss with no reads → ss_tready drops after the 8th and rx_count=8. Eight RXDATA reads return 0xA0..0xA7 in order.
- RXDATA read when empty → stalls. Inject ss beat 0x55 → read acks 2 edges later with wbs_dat_o=0x55.
- With WB_AXIS_TLAST_EN: TXLAST write 0x7 → sm_tlast=1 with sm_tdata=7. ss beat with tlast=1 → STATUS[4]=1 before the pop.
- Assert rst_n low while the TX FIFO holds 3 words and an RX read is stalled → all outputs go to 0 immediately, and STATUS after release reads 0x0000_000A.
